rsa_mont_exp: RTL

- Bit-serial Montgomery modular exponentiation core: C = M^E mod P, operands WIDTH bits wide.
- Sits directly downstream of the RSA enable/controller logic. It consumes that logic's en_rsa and rst_rsa, and returns eoc_rsa_unit.
- Its C result is written into the result register (addr 6) of the SPI register bank.
- Operands P, E, M and Const come from register-bank addrs 2–5.

---
 rtl/rsa_mont_exp.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rsa_mont_exp.sv
// Bit-serial Montgomery modular exponentiation C = M^E mod P, with one shared
// WIDTH+1 cycle Montgomery multiplier. Define RSA_FAST_EXP_EN to skip MUL for zero exponent bits.
module rsa_mont_exp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Const,
    output logic             busy,
    output logic             eoc,
    output logic [WIDTH-1:0] C,
    output logic [2:0]       state_dbg
);

    localparam int SW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE_M = 3'd1,
        S_PRE_X = 3'd2,
        S_SQR   = 3'd3,
        S_MUL   = 3'd4,
        S_POST  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   k_q, k_d;
    logic [SW-1:0]   s_q, s_d;
    logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d, const_q, const_d;
    logic [WIDTH-1:0] mb_q, mb_d, xb_q, xb_d, c_q, c_d;

    logic [WIDTH-1:0] a_op, b_op, p_op, mont_res;
    logic             a_bit, last;
    logic [SW-1:0]    s_add, s_odd, s_step, s_red;

    // The start cycle is already the first iteration of mont(M,Const), so the
    // operands come straight from the ports while still in IDLE.
    always_comb begin
        a_op = '0;
        b_op = '0;
        case (state_q)
            S_IDLE:  begin a_op = M;    b_op = Const;   end
            S_PRE_M: begin a_op = m_q;  b_op = const_q; end
            S_PRE_X: begin a_op = WIDTH'(1); b_op = const_q; end
            S_SQR:   begin a_op = xb_q; b_op = xb_q;    end
            S_MUL:   begin a_op = xb_q; b_op = mb_q;    end
            S_POST:  begin a_op = xb_q; b_op = WIDTH'(1); end
            default: begin a_op = '0;   b_op = '0;      end
        endcase
    end

    assign p_op     = (state_q == S_IDLE) ? P : p_q;
    assign a_bit    = a_op[cnt_q[IW-1:0]];
    assign s_add    = s_q + (a_bit ? {2'b00, b_op} : {SW{1'b0}});
    assign s_odd    = s_add[0] ? s_add + {2'b00, p_op} : s_add;
    assign s_step   = s_odd >> 1;
    assign s_red    = (s_q >= {2'b00, p_q}) ? s_q - {2'b00, p_q} : s_q;
    assign mont_res = s_red[WIDTH-1:0];
    assign last     = (cnt_q == CW'(WIDTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        s_d     = s_q;
        p_d     = p_q;
        e_d     = e_q;
        m_d     = m_q;
        const_d = const_q;
        mb_d    = mb_q;
        xb_d    = xb_q;
        c_d     = c_q;
        if (en) begin
            if (state_q == S_IDLE) begin
                p_d     = P;
                e_d     = E;
                m_d     = M;
                const_d = Const;
                k_d     = IW'(WIDTH - 1);
                s_d     = s_step;
                cnt_d   = CW'(1);
                state_d = S_PRE_M;
            end else if (state_q != S_DONE) begin
                if (!last) begin
                    s_d   = s_step;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    s_d   = '0;
                    cnt_d = '0;
                    case (state_q)
                        S_PRE_M: begin
                            mb_d    = mont_res;
                            state_d = S_PRE_X;
                        end
                        S_PRE_X: begin
                            xb_d    = mont_res;
                            state_d = S_SQR;
                        end
                        S_SQR: begin
                            xb_d = mont_res;
`ifdef RSA_FAST_EXP_EN
                            if (e_q[k_q]) begin
                                state_d = S_MUL;
                            end else if (k_q == '0) begin
                                state_d = S_POST;
                            end else begin
                                k_d     = k_q - IW'(1);
                                state_d = S_SQR;
                            end
`else
                            state_d = S_MUL;
`endif
                        end
                        S_MUL: begin
                            // MUL always runs; only the write-back depends on E.
                            if (e_q[k_q]) begin
                                xb_d = mont_res;
                            end
                            if (k_q == '0) begin
                                state_d = S_POST;
                            end else begin
                                k_d     = k_q - IW'(1);
                                state_d = S_SQR;
                            end
                        end
                        S_POST: begin
                            c_d     = mont_res;
                            state_d = S_DONE;
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            s_q     <= '0;
            p_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            const_q <= '0;
            mb_q    <= '0;
            xb_q    <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            s_q     <= s_d;
            p_q     <= p_d;
            e_q     <= e_d;
            m_q     <= m_d;
            const_q <= const_d;
            mb_q    <= mb_d;
            xb_q    <= xb_d;
            c_q     <= c_d;
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign eoc       = (state_q == S_DONE);
    assign C         = c_q;
    assign state_dbg = state_q;

endmodule
